mem_access: RTL and testbench

MEM stage of the five-stage core: consumes the EX result (ALU/Logic result or effective address) and the store operand, runs loads and stores against the data RAM with a req/ack handshake, and registers the write-back bundle for MEM/WB. It stalls the pipeline while a RAM access is outstanding. It also handles byte/half/word lane selection, sign/zero extension, misalignment detection and an ack timeout.

---
 rtl/mem_access.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM stage of the five-stage core.
// Runs loads/stores against the data RAM over a req/ack handshake, selects
// byte lanes, extends loaded data, flags misaligned accesses and ack
// timeouts, and registers the write-back bundle for MEM/WB.
module mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_result,
   input  logic [31:0] in_store_data,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [1:0]  in_size,
   input  logic        in_sign_ext,
   input  logic        in_reg_we,
   input  logic [4:0]  in_reg_addr,
   output logic        stall_req,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [3:0]  ram_sel,
   output logic [31:0] ram_wdata,
   input  logic        ram_ack,
   input  logic [31:0] ram_rdata,
   output logic        wb_valid,
   output logic        wb_reg_we,
   output logic [4:0]  wb_reg_addr,
   output logic [31:0] wb_data,
   output logic        wb_addr_error,
   output logic        wb_bus_error,
   output logic [31:0] wb_bad_addr
);

   localparam int unsigned CNT_W = 32;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ram_req_q, ram_req_d;
   logic             ram_we_q, ram_we_d;
   logic [31:0]      ram_addr_q, ram_addr_d;
   logic [3:0]       ram_sel_q, ram_sel_d;
   logic [31:0]      ram_wdata_q, ram_wdata_d;
   logic             wb_valid_q, wb_valid_d;
   logic             wb_reg_we_q, wb_reg_we_d;
   logic [4:0]       wb_reg_addr_q, wb_reg_addr_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             wb_addr_error_q, wb_addr_error_d;
   logic             wb_bus_error_q, wb_bus_error_d;
   logic [31:0]      wb_bad_addr_q, wb_bad_addr_d;

   logic             mem_op_c;
   logic             misaligned_c;
   logic             timeout_hit_c;
   logic [3:0]       sel_c;
   logic [31:0]      wdata_c;
   logic [7:0]       byte_c;
   logic [15:0]      half_c;
   logic [31:0]      load_c;

   // Decode the access: lane enables, replicated store data, alignment
   always_comb begin
      mem_op_c     = in_valid & (in_mem_read | in_mem_write);
      misaligned_c = 1'b0;
      sel_c        = 4'b1111;
      wdata_c      = in_store_data;
      case (in_size)
         2'b00: begin
            sel_c   = 4'b0001 << in_result[1:0];
            wdata_c = {4{in_store_data[7:0]}};
         end
         2'b01: begin
            misaligned_c = in_result[0];
            sel_c        = in_result[1] ? 4'b1100 : 4'b0011;
            wdata_c      = {2{in_store_data[15:0]}};
         end
         default: begin
            misaligned_c = (in_result[1:0] != 2'b00);
         end
      endcase
   end

   // Extract the addressed lane from read data and extend it
   always_comb begin
      byte_c = 8'(ram_rdata >> {in_result[1:0], 3'b000});
      half_c = in_result[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (in_size)
         2'b00:   load_c = {{24{in_sign_ext & byte_c[7]}}, byte_c};
         2'b01:   load_c = {{16{in_sign_ext & half_c[15]}}, half_c};
         default: load_c = ram_rdata;
      endcase
   end

   // Timeout fires on the BUSY cycle whose count would reach TIMEOUT
   always_comb begin
      timeout_hit_c = (TIMEOUT != 0) && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));
   end

   // Next-state and output logic
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      ram_req_d       = ram_req_q;
      ram_we_d        = ram_we_q;
      ram_addr_d      = ram_addr_q;
      ram_sel_d       = ram_sel_q;
      ram_wdata_d     = ram_wdata_q;
      wb_valid_d      = 1'b0;
      wb_reg_we_d     = 1'b0;
      wb_reg_addr_d   = wb_reg_addr_q;
      wb_data_d       = wb_data_q;
      wb_addr_error_d = 1'b0;
      wb_bus_error_d  = 1'b0;
      wb_bad_addr_d   = wb_bad_addr_q;
      stall_req       = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (in_valid && !mem_op_c) begin
               wb_valid_d    = 1'b1;
               wb_data_d     = in_result;
               wb_reg_we_d   = in_reg_we;
               wb_reg_addr_d = in_reg_addr;
            end else if (mem_op_c && misaligned_c) begin
               wb_valid_d      = 1'b1;
               wb_reg_addr_d   = in_reg_addr;
               wb_addr_error_d = 1'b1;
               wb_bad_addr_d   = in_result;
            end else if (mem_op_c) begin
               stall_req   = 1'b1;
               ram_req_d   = 1'b1;
               ram_we_d    = in_mem_write;
               ram_addr_d  = {in_result[31:2], 2'b00};
               ram_sel_d   = sel_c;
               ram_wdata_d = wdata_c;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            stall_req = 1'b1;
            if (ram_ack) begin
               ram_req_d     = 1'b0;
               ram_we_d      = 1'b0;
               state_d       = S_DONE;
               wb_valid_d    = 1'b1;
               wb_reg_addr_d = in_reg_addr;
               if (in_mem_read) begin
                  wb_data_d   = load_c;
                  wb_reg_we_d = in_reg_we;
               end
            end else if (timeout_hit_c) begin
               ram_req_d      = 1'b0;
               ram_we_d       = 1'b0;
               state_d        = S_DONE;
               wb_valid_d     = 1'b1;
               wb_reg_addr_d  = in_reg_addr;
               wb_bus_error_d = 1'b1;
               wb_bad_addr_d  = in_result;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         ram_req_q       <= 1'b0;
         ram_we_q        <= 1'b0;
         ram_addr_q      <= '0;
         ram_sel_q       <= '0;
         ram_wdata_q     <= '0;
         wb_valid_q      <= 1'b0;
         wb_reg_we_q     <= 1'b0;
         wb_reg_addr_q   <= '0;
         wb_data_q       <= '0;
         wb_addr_error_q <= 1'b0;
         wb_bus_error_q  <= 1'b0;
         wb_bad_addr_q   <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         ram_req_q       <= ram_req_d;
         ram_we_q        <= ram_we_d;
         ram_addr_q      <= ram_addr_d;
         ram_sel_q       <= ram_sel_d;
         ram_wdata_q     <= ram_wdata_d;
         wb_valid_q      <= wb_valid_d;
         wb_reg_we_q     <= wb_reg_we_d;
         wb_reg_addr_q   <= wb_reg_addr_d;
         wb_data_q       <= wb_data_d;
         wb_addr_error_q <= wb_addr_error_d;
         wb_bus_error_q  <= wb_bus_error_d;
         wb_bad_addr_q   <= wb_bad_addr_d;
      end
   end

   assign ram_req       = ram_req_q;
   assign ram_we        = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_sel       = ram_sel_q;
   assign ram_wdata     = ram_wdata_q;
   assign wb_valid      = wb_valid_q;
   assign wb_reg_we     = wb_reg_we_q;
   assign wb_reg_addr   = wb_reg_addr_q;
   assign wb_data       = wb_data_q;
   assign wb_addr_error = wb_addr_error_q;
   assign wb_bus_error  = wb_bus_error_q;
   assign wb_bad_addr   = wb_bad_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, randomized operations checked
// against an arithmetic reference model, and a reset-during-access sequence.
module tb_mem_access;

   localparam int unsigned TMO = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_result;
   logic [31:0] in_store_data;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [1:0]  in_size;
   logic        in_sign_ext;
   logic        in_reg_we;
   logic [4:0]  in_reg_addr;
   logic        stall_req;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [3:0]  ram_sel;
   logic [31:0] ram_wdata;
   logic        ram_ack;
   logic [31:0] ram_rdata;
   logic        wb_valid;
   logic        wb_reg_we;
   logic [4:0]  wb_reg_addr;
   logic [31:0] wb_data;
   logic        wb_addr_error;
   logic        wb_bus_error;
   logic [31:0] wb_bad_addr;

   int n_tests;
   int n_fail;

   mem_access #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_result(in_result),
      .in_store_data(in_store_data), .in_mem_read(in_mem_read),
      .in_mem_write(in_mem_write), .in_size(in_size), .in_sign_ext(in_sign_ext),
      .in_reg_we(in_reg_we), .in_reg_addr(in_reg_addr), .stall_req(stall_req),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
      .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .wb_valid(wb_valid), .wb_reg_we(wb_reg_we), .wb_reg_addr(wb_reg_addr),
      .wb_data(wb_data), .wb_addr_error(wb_addr_error),
      .wb_bus_error(wb_bus_error), .wb_bad_addr(wb_bad_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One operation with its expected outcome; ack_cyc = BUSY cycle carrying ack (0 = never)
   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        sx;
      logic        rwe;
      logic [4:0]  ra;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      int          ack_cyc;
      int          busy;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] data;
      logic        chk_data;
      logic        we;
      logic        aerr;
      logic        berr;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: fills expectations from the access rules
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int          nb;
      int          off;
      logic        is_mem;
      logic        acked;
      logic [63:0] mask;
      logic [31:0] raw;
      logic [31:0] m32;
      r      = v;
      nb     = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
      off    = int'(v.addr % 32'd4);
      is_mem = v.rd | v.wr;
      mask   = (64'd1 << (8 * nb)) - 64'd1;
      m32    = mask[31:0];
      r.sel  = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = v.sdata[8*(i % nb) +: 8];
      r.aerr = 1'b0; r.berr = 1'b0; r.chk_data = 1'b0; r.we = 1'b0; r.data = '0; r.busy = 0;
      if (!is_mem) begin
         r.we = v.rwe; r.data = v.addr; r.chk_data = 1'b1;
      end else if ((v.addr % 32'(nb)) != 0) begin
         r.aerr = 1'b1;
      end else begin
         acked  = (v.ack_cyc != 0) && (v.ack_cyc <= int'(TMO));
         r.busy = acked ? v.ack_cyc : int'(TMO);
         r.berr = !acked;
         if (acked && v.rd) begin
            raw = (v.rdata >> (8 * off)) & m32;
            if (v.sx && nb < 4 && raw[8*nb-1]) raw = raw | ~m32;
            r.data = raw; r.chk_data = 1'b1; r.we = v.rwe;
         end
      end
      return r;
   endfunction

   task automatic check_wb(input vec_t v);
      chk("wb_valid", 32'(wb_valid), 32'(1'b1));
      chk("wb_addr_error", 32'(wb_addr_error), 32'(v.aerr));
      chk("wb_bus_error", 32'(wb_bus_error), 32'(v.berr));
      chk("wb_reg_we", 32'(wb_reg_we), 32'(v.we));
      chk("stall_release", 32'(stall_req), 32'(1'b0));
      chk("ram_req_off", 32'(ram_req), 32'(1'b0));
      if (v.we) chk("wb_reg_addr", 32'(wb_reg_addr), 32'(v.ra));
      if (v.aerr || v.berr) chk("wb_bad_addr", wb_bad_addr, v.addr);
      if (v.chk_data) chk("wb_data", wb_data, v.data);
   endtask

   task automatic run_op(input vec_t v);
      in_valid = 1'b1; in_mem_read = v.rd; in_mem_write = v.wr; in_size = v.size;
      in_sign_ext = v.sx; in_reg_we = v.rwe; in_reg_addr = v.ra; in_result = v.addr;
      in_store_data = v.sdata; ram_rdata = v.rdata; ram_ack = 1'b0;
      @(negedge clk);
      if (v.busy == 0) begin
         chk("stall_none", 32'(stall_req), 32'(1'b0));
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         check_wb(v);
      end else begin
         chk("stall_idle", 32'(stall_req), 32'(1'b1));
         chk("ram_req_idle", 32'(ram_req), 32'(1'b0));
         for (int k = 1; k <= v.busy; k++) begin
            @(posedge clk); #1;
            ram_ack = (k == v.ack_cyc);
            @(negedge clk);
            chk("ram_req_busy", 32'(ram_req), 32'(1'b1));
            chk("stall_busy", 32'(stall_req), 32'(1'b1));
            chk("ram_we", 32'(ram_we), 32'(v.wr));
            chk("ram_addr", ram_addr, {v.addr[31:2], 2'b00});
            chk("ram_sel", 32'(ram_sel), 32'(v.sel));
            if (v.wr) chk("ram_wdata", ram_wdata, v.wdata);
         end
         @(posedge clk); #1;
         ram_ack = 1'b0;
         @(negedge clk);
         check_wb(v);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("wb_valid_clear", 32'(wb_valid), 32'(1'b0));
      chk("err_clear", 32'({wb_addr_error, wb_bus_error}), 32'(2'b00));
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_stall"}, 32'(stall_req), 32'(1'b0));
      chk({nm, "_ram_ctl"}, 32'({ram_req, ram_we, ram_sel}), 32'(6'b0));
      chk({nm, "_ram_addr"}, ram_addr, 32'h0);
      chk({nm, "_ram_wdata"}, ram_wdata, 32'h0);
      chk({nm, "_wb_flags"}, 32'({wb_valid, wb_reg_we, wb_addr_error, wb_bus_error}), 32'(4'b0));
      chk({nm, "_wb_reg_addr"}, 32'(wb_reg_addr), 32'h0);
      chk({nm, "_wb_data"}, wb_data, 32'h0);
      chk({nm, "_wb_bad_addr"}, wb_bad_addr, 32'h0);
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b0; in_valid = 1'b0; in_result = '0; in_store_data = '0;
      in_mem_read = 1'b0; in_mem_write = 1'b0; in_size = 2'b00; in_sign_ext = 1'b0;
      in_reg_we = 1'b0; in_reg_addr = '0; ram_ack = 1'b0; ram_rdata = '0;

      //           rd    wr    size   sx    rwe   ra     addr          sdata         rdata         ack busy sel       wdata         data          chk   we    aerr  berr
      tbl.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5,  32'h12345678, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd7,  32'h00001003, 32'h0,        32'h80FFFFFF, 2, 2, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 5'd8,  32'h00002002, 32'h0000ABCD, 32'h0,        1, 1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9,  32'h00003001, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd10, 32'h00004000, 32'h0,        32'h00000055, 0, 4, 4'b1111, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd11, 32'h00005002, 32'h0,        32'h87654321, 1, 1, 4'b1100, 32'h0,        32'h00008765, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 5'd12, 32'h00005000, 32'h0,        32'h1234F00D, 1, 1, 4'b0011, 32'h0,        32'hFFFFF00D, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 5'd0,  32'h00006001, 32'h123456A5, 32'h0,        3, 3, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 5'd13, 32'h00007000, 32'h0,        32'hDEADBEEF, 4, 4, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0,  32'h00008001, 32'h00000001, 32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 5'd0,  32'h00009004, 32'h11223344, 32'h0,        1, 1, 4'b1111, 32'h11223344, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd14, 32'h0000A002, 32'h0,        32'h00FE0000, 1, 1, 4'b0100, 32'h0,        32'h000000FE, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd16, 32'h0000B000, 32'h0,        32'hFFFFFF7F, 1, 1, 4'b0001, 32'h0,        32'h0000007F, 1'b1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 5'd15, 32'h0000C008, 32'h0,        32'hCAFEF00D, 1, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0});

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table
      foreach (tbl[i]) run_op(tbl[i]);

      // Randomized operations against the model
      for (int n = 0; n < 60; n++) begin
         int kind;
         kind     = int'($urandom_range(0, 4));
         rv.rd    = (kind == 1) || (kind == 2);
         rv.wr    = (kind == 3) || (kind == 4);
         rv.size  = 2'($urandom_range(0, 3));
         rv.sx    = 1'($urandom);
         rv.rwe   = 1'($urandom);
         rv.ra    = 5'($urandom);
         rv.addr  = $urandom & 32'h0000FFFF;
         rv.sdata = $urandom;
         rv.rdata = $urandom;
         rv.ack_cyc = int'($urandom_range(0, 5));
         run_op(model(rv));
      end

      // Reset while BUSY, then a late ack that must be ignored
      in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_size = 2'd2;
      in_sign_ext = 1'b0; in_reg_we = 1'b1; in_reg_addr = 5'd3;
      in_result = 32'h0000D000; ram_rdata = 32'h13579BDF; ram_ack = 1'b0;
      @(negedge clk);
      chk("rst_seq_stall", 32'(stall_req), 32'(1'b1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_seq_busy_req", 32'(ram_req), 32'(1'b1));
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; ram_ack = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_busy");
      @(posedge clk); #1;
      ram_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_wb_valid", 32'(wb_valid), 32'(1'b0));
      chk("late_ack_ram_req", 32'(ram_req), 32'(1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("late_ack_quiet", 32'({wb_valid, stall_req, ram_req}), 32'(3'b000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
